conv_result_collector: RTL
==========================

CONV_RESULT_COLLECTOR -- requirements
Module: conv_result_collector

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- DATA_WIDTH, 8, result element width.
- RESULT_W, 6, result columns.
- RESULT_H, 6, result rows.
- RESULT_D, 4, result channels.
- RESULT_H_ADDR_WIDTH, $clog2(RESULT_H), row address width.
- LANES, RESULT_D*RESULT_W, derived and not set manually.
REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- result_wraddress, in, LANES*RESULT_H_ADDR_WIDTH, per-lane row address from the conv array; lane index = d*RESULT_W + w.
- result_data_out, in, LANES*DATA_WIDTH, per-lane result value.
- result_wren, in, LANES, per-lane write strobe.
- out_data, out, LANES*DATA_WIDTH, one complete result row, all channels.
- out_row, out, RESULT_H_ADDR_WIDTH, row index of out_data.
- out_last, out, 1, high when out_row == RESULT_H-1.
- out_val, out, 1, row offered.
- out_rdy, in, 1, consumer accepts.
- frame_done, out, 1, one-cycle pulse when the last row is accepted.
- err, out, 1, sticky error flag.

Function
REQ-003 The block shall hold storage of RESULT_H x LANES elements and a RESULT_H x LANES written-bitmap.
REQ-004 For each lane with wren=1 and address < RESULT_H, the block shall write data to [addr][lane] and set bit [addr][lane] at the next clock edge. Lanes are independent, and any mix of lanes may write in one cycle.
REQ-005 A write with address >= RESULT_H shall be discarded and shall set err.
REQ-006 A write to a lane whose bit is already set shall overwrite the data and shall set err.
REQ-007 A row is complete when all LANES bits of that row are set.
REQ-008 A read pointer rd_ptr shall select the offered row:
- out_val = complete(rd_ptr).
- out_row = rd_ptr.
- out_data = storage[rd_ptr], combinational from registers.
REQ-009 Latency: a write completing row rd_ptr at edge t shall make out_val=1 in the cycle following t, with no extra delay.
REQ-010 Handshake: when out_val && out_rdy at an edge, the block shall:
- clear that row's bitmap;
- advance rd_ptr, wrapping RESULT_H-1 -> 0;
- assert frame_done in the next cycle when the accepted row was RESULT_H-1.
REQ-011 While out_val=1 and out_rdy=0, out_row shall be held. out_data shall be held unless an overwrite (REQ-006) occurs.
REQ-012 Rows complete out of order shall be buffered and shall be emitted strictly in ascending row order.
REQ-013 Simultaneous handshake-clear and write on the same [row][lane] shall leave the bit set and the new data stored. The write is treated as next-frame data, and err shall not be set.
REQ-014 Writes to already-drained rows shall accumulate as next-frame data, with no frame-boundary stall.
REQ-015 The block shall have no back-pressure path upstream. If the consumer stalls past a frame, the only visible effect is err via REQ-006.

Reset
REQ-016 When reset is asserted, the block shall, at the clock edge:
- clear all bitmap bits;
- set rd_ptr=0;
- set err=0, out_val=0, frame_done=0.
Storage data contents may remain unreset.
REQ-017 Reset mid-frame shall discard all partial rows. The first row offered after reset shall be row 0.

Structure
REQ-018 LANES and any lane-index helper shall be defined in the shared conv_2d package, alongside the conv array's parameters.
REQ-019 Each lane's column storage (RESULT_H entries, write port, read by rd_ptr) shall be one sub-module, conv_result_lane_buf, instantiated LANES times. The bitmap, pointer and handshake logic shall be kept in the top level.

Verification
REQ-020 Use RESULT_W=2, RESULT_H=3, RESULT_D=1 (LANES=2) unless stated otherwise.
REQ-021 Single row: write rows 0..2 on both lanes in consecutive cycles with data {row*10+lane}, out_rdy=1. Required response:
- out_val pulses with out_row 0,1,2 in the cycle after each write;
- out_data {0,1}, {10,11}, {20,21};
- frame_done pulses once, after row 2.
REQ-022 Out-of-order completion: write row 1 (both lanes), then row 0 lane 0, then row 0 lane 1. Required response:
- out_val stays 0 until row 0 is complete;
- row 0 is offered, then row 1 on the next cycle.
REQ-023 Stall: row 0 complete with out_rdy=0 for 5 cycles. Required response:
- out_val=1 and out_row=0 are held stable for all 5 cycles;
- the row is accepted when out_rdy=1, and rd_ptr=1 afterward.
REQ-024 Errors, each checked against err sticky at 1 until reset:
- a write with address 3 (>= RESULT_H);
- a second write to [0][lane 0] before row 0 is drained, after which out_data shows the newer value.
REQ-025 Frame wrap with same-cycle write: accept row 2 while lane 0 writes row 2 of the next frame in that cycle. Required response:
- the bit remains set and err stays 0;
- next-frame row 2 completes after lane 1 writes;
- it is offered only after rows 0 and 1 of the new frame.
REQ-026 Reset mid-frame: with rows 0..1 partially written, assert reset for 1 cycle. Required response:
- out_val=0 and err=0;
- a new full frame is emitted from row 0 correctly.

Source files
------------

// File: rtl/conv_2d_pkg.sv
// ---------------------------------------------------------------------------
// conv_2d_pkg
// Shared definitions for the 2-D convolution datapath. The conv array and
// the result collector both derive their lane count and lane numbering from
// here, so the two sides always agree on how lanes map to (channel, column).
//
// Contents:
//   CONV_* localparams   default geometry of the conv array result tile
//   conv_lanes()         number of parallel result lanes for a geometry
//   conv_lane_index()    lane number of result element (d, w)
// ---------------------------------------------------------------------------
package conv_2d_pkg;

  // Default result tile geometry produced by the conv array.
  localparam int CONV_DATA_WIDTH = 8;
  localparam int CONV_RESULT_W   = 6;
  localparam int CONV_RESULT_H   = 6;
  localparam int CONV_RESULT_D   = 4;

  // One lane per (channel, column) pair of a result row.
  function automatic int conv_lanes(input int result_w, input int result_d);
    return result_w * result_d;
  endfunction

  // Lanes are numbered channel-major: all columns of channel 0 first.
  function automatic int conv_lane_index(input int d, input int w,
                                         input int result_w);
    return d * result_w + w;
  endfunction

  localparam int CONV_LANES = conv_lanes(CONV_RESULT_W, CONV_RESULT_D);

endpackage : conv_2d_pkg

// File: rtl/conv_result_lane_buf.sv
// ---------------------------------------------------------------------------
// conv_result_lane_buf
// Column storage for one result lane: DEPTH row entries, one write port
// driven by the conv array and one combinational read port addressed by the
// collector's read pointer. Contents are not reset; validity is tracked by
// the written-bitmap in the collector top level.
//
// Ports:
//   clk       clock
//   wr_en     write strobe (already qualified: address is in range)
//   wr_addr   row to write
//   wr_data   value to store
//   rd_addr   row to present on rd_data
//   rd_data   stored value of row rd_addr, straight from the registers
// ---------------------------------------------------------------------------
module conv_result_lane_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 6,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_d;

  // Next contents: only the addressed entry changes on a write. The caller
  // guarantees wr_addr < DEPTH whenever wr_en is high.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Storage is deliberately left out of reset; stale data is never offered
  // because the bitmap in the top level is cleared instead.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule : conv_result_lane_buf

// File: rtl/conv_result_collector.sv
// ---------------------------------------------------------------------------
// conv_result_collector
// Gathers per-lane result writes from the conv array, which may arrive in
// any order and any lane mix, and re-emits them as complete result rows in
// strictly ascending row order over a valid/ready interface. There is no
// back-pressure towards the conv array: writes are always accepted, and a
// write that lands on an undrained element or outside the tile only raises
// the sticky err flag.
//
// Ports:
//   clk               clock
//   reset             synchronous, active-high
//   result_wraddress  per-lane row address, lane = d*RESULT_W + w
//   result_data_out   per-lane result value
//   result_wren       per-lane write strobe
//   out_data          all lanes of row out_row (lane l at bits l*DATA_WIDTH)
//   out_row           row currently offered (the read pointer)
//   out_last          out_row is the last row of the tile
//   out_val           row out_row is complete and offered
//   out_rdy           consumer takes the offered row
//   frame_done        one-cycle pulse after the last row is taken
//   err               sticky: out-of-range write or overwrite of live data
// ---------------------------------------------------------------------------
module conv_result_collector
  import conv_2d_pkg::*;
#(
  parameter  int DATA_WIDTH          = CONV_DATA_WIDTH,
  parameter  int RESULT_W            = CONV_RESULT_W,
  parameter  int RESULT_H            = CONV_RESULT_H,
  parameter  int RESULT_D            = CONV_RESULT_D,
  parameter  int RESULT_H_ADDR_WIDTH = $clog2(RESULT_H),
  localparam int LANES               = conv_lanes(RESULT_W, RESULT_D)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [LANES*RESULT_H_ADDR_WIDTH-1:0] result_wraddress,
  input  logic [LANES*DATA_WIDTH-1:0]          result_data_out,
  input  logic [LANES-1:0]                     result_wren,
  output logic [LANES*DATA_WIDTH-1:0]          out_data,
  output logic [RESULT_H_ADDR_WIDTH-1:0]       out_row,
  output logic                                 out_last,
  output logic                                 out_val,
  input  logic                                 out_rdy,
  output logic                                 frame_done,
  output logic                                 err
);

  localparam int AW = RESULT_H_ADDR_WIDTH;

  // Row count widened by one bit so the range check also works when
  // RESULT_H is a power of two.
  localparam logic [AW:0]   ROWS_EXT = (AW+1)'(RESULT_H);
  localparam logic [AW-1:0] LAST_ROW = AW'(RESULT_H - 1);

  logic [AW-1:0]         lane_addr  [LANES];
  logic [DATA_WIDTH-1:0] lane_wdata [LANES];
  logic [LANES-1:0]      addr_ok;
  logic [LANES-1:0]      wr_ok;
  logic [LANES-1:0]      oob_hit;
  logic [LANES-1:0]      overwrite_hit;

  logic [RESULT_H-1:0][LANES-1:0] bitmap_q;
  logic [RESULT_H-1:0][LANES-1:0] bitmap_d;
  logic [AW-1:0]                  rd_ptr_q;
  logic [AW-1:0]                  rd_ptr_d;
  logic                           err_q;
  logic                           err_d;
  logic                           frame_done_q;
  logic                           frame_done_d;

  logic row_complete;
  logic accept;

  // Per-lane unpacking, address qualification and column storage. Only
  // in-range writes reach the storage; out-of-range ones are flagged.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_addr[l]  = result_wraddress[l*AW +: AW];
    assign lane_wdata[l] = result_data_out[l*DATA_WIDTH +: DATA_WIDTH];
    assign addr_ok[l]    = ({1'b0, lane_addr[l]} < ROWS_EXT);
    assign wr_ok[l]      = result_wren[l] & addr_ok[l];
    assign oob_hit[l]    = result_wren[l] & ~addr_ok[l];

    conv_result_lane_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RESULT_H),
      .ADDR_WIDTH (AW)
    ) u_buf (
      .clk     (clk),
      .wr_en   (wr_ok[l]),
      .wr_addr (lane_addr[l]),
      .wr_data (lane_wdata[l]),
      .rd_addr (rd_ptr_q),
      .rd_data (out_data[l*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // The offered row is valid as soon as its bitmap is full, so a write that
  // completes row rd_ptr shows up as out_val in the very next cycle.
  assign row_complete = &bitmap_q[rd_ptr_q];
  assign accept       = row_complete & out_rdy;

  // Bitmap update. The handshake clear is applied first and lane writes are
  // layered on top, so a write hitting the row being drained in the same
  // cycle survives as next-frame data. That case is also the only one where
  // a set bit may be written without counting as an overwrite: the old
  // value is leaving through the handshake at this very edge.
  always_comb begin
    bitmap_d      = bitmap_q;
    overwrite_hit = '0;
    if (accept) begin
      bitmap_d[rd_ptr_q] = '0;
    end
    for (int l = 0; l < LANES; l++) begin
      if (wr_ok[l]) begin
        if (bitmap_q[lane_addr[l]][l] &&
            !(accept && (lane_addr[l] == rd_ptr_q))) begin
          overwrite_hit[l] = 1'b1;
        end
        bitmap_d[lane_addr[l]][l] = 1'b1;
      end
    end
  end

  // Read pointer, frame-done pulse and sticky error.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    frame_done_d = 1'b0;
    if (accept) begin
      if (rd_ptr_q == LAST_ROW) begin
        rd_ptr_d     = '0;
        frame_done_d = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
    err_d = err_q | (|oob_hit) | (|overwrite_hit);
  end

  // Control state. Reset drops every partial row so the first row offered
  // afterwards is always row 0 of a fresh frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      bitmap_q     <= '0;
      rd_ptr_q     <= '0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      bitmap_q     <= bitmap_d;
      rd_ptr_q     <= rd_ptr_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_val    = row_complete;
  assign out_row    = rd_ptr_q;
  assign out_last   = (rd_ptr_q == LAST_ROW);
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule : conv_result_collector
